svc_axi_axil_burst_rd: RTL and testbench
========================================

# svc_axi_axil_burst_rd

AXI-to-AXI-Lite read bridge that accepts full AXI read bursts (FIXED and INCR, optionally WRAP) and splits each burst into single-beat AXI-Lite reads. It reflects ARID/ARUSER onto every R beat, generates RLAST, and tracks beats in flight so that responses stay correctly tagged. It sits between an AXI manager, such as a cache or DMA, and AXI-Lite-only subordinates. Compared with the single-beat reflector, it removes the arlen == 0 restriction.

## Interface
- AXI_ADDR_WIDTH, 8, address width on both sides
- AXI_DATA_WIDTH, 16, data width; byte count BYTES = AXI_DATA_WIDTH/8
- AXI_ID_WIDTH, 4, ARID/RID width
- AXI_USER_WIDTH, 1, ARUSER/RUSER width
- OUTSTANDING_READS_WIDTH, 2, log2 of beat-tracking FIFO depth (max AXI-Lite reads in flight)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- s_axi_arvalid/arready  in/out  1  AR handshake
- s_axi_arid  in  AXI_ID_WIDTH  burst ID
- s_axi_araddr  in  AXI_ADDR_WIDTH  start address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  0 FIXED, 1 INCR, 2 WRAP
- s_axi_aruser  in  AXI_USER_WIDTH  user sideband
- s_axi_rvalid/rready  out/in  1  R handshake
- s_axi_rid, s_axi_ruser  out  ID/USER widths  reflected from the owning AR
- s_axi_rdata  out  AXI_DATA_WIDTH  pass-through
- s_axi_rresp  out  2  pass-through
- s_axi_rlast  out  1  high on the final beat of each burst
- m_axil_arvalid/arready  out/in  1  AXI-Lite AR handshake
- m_axil_araddr  out  AXI_ADDR_WIDTH  per-beat address
- m_axil_rvalid/rready  in/out  1  AXI-Lite R handshake
- m_axil_rdata  in  AXI_DATA_WIDTH, m_axil_rresp in 2

## Operation
- FSM states:
  - IDLE: s_axi_arready = 1. On AR handshake, register addr, len, size (clamped to log2(BYTES)), burst, id and user; set beat counter to 0; go to ISSUE.
  - ISSUE: s_axi_arready = 0. m_axil_arvalid = 1 while the tracker is not full.
    - On each m_axil AR handshake, push {id, user, last = (beat == len)} into the tracker.
    - Advance the address and increment the beat counter.
    - After the handshake with last = 1, return to IDLE.
- Address advance:
  - FIXED: address unchanged.
  - INCR: next = (addr & ~(2^size-1)) + 2^size, modulo 2^AXI_ADDR_WIDTH. The 4 KB boundary is not checked.
  - WRAP: see Configuration.
- Tracker is a sync FIFO of depth 2^OUTSTANDING_READS_WIDTH.
  - s_axi_rvalid = m_axil_rvalid && tracker non-empty.
  - m_axil_rready = s_axi_rready && tracker non-empty.
  - rid, ruser and rlast are taken from the tracker head, which pops on the s_axi R handshake.
  - An AXI-Lite R arriving with the tracker empty is a protocol violation. It is held (rready = 0) and never forwarded.
- Simultaneous tracker push and pop in one cycle are both performed. When the tracker is full, a pop in the same cycle does not allow a push that cycle.
- rresp is passed per beat. There is no error aggregation.

## Timing
- Reset values:
  - s_axi_arready 0 during rst, 1 on the first cycle after.
  - m_axil_arvalid 0; m_axil_araddr 0.
  - s_axi_rvalid 0 and m_axil_rready 0, because the tracker is empty.
  - s_axi_rlast 0; s_axi_rid and s_axi_ruser 0.
- AR accept at cycle N produces the first m_axil_arvalid at N+1. With arready held high, subsequent beats issue back-to-back, one per cycle.
- The next burst's AR is accepted no earlier than the cycle after the last beat issues, so there is one idle AR cycle between bursts.
- The R path is combinational pass-through with zero added latency. There is no combinational path from m_axil_arready to s_axi_arready.
- m_axil_arvalid is held with stable araddr until m_axil_arready is sampled high.
- rst asserted mid-burst:
  - FSM returns to IDLE and the tracker is flushed.
  - Any in-flight AXI-Lite responses are the environment's responsibility.

## Configuration
- SVC_AXI_AXIL_BURST_RD_WRAP_EN defined:
  - WRAP bursts are supported for len ∈ {1,3,7,15}.
  - Wrap span = 2^size*(len+1); next = lower + ((addr+2^size − lower) mod span), where lower = addr aligned down to span.
- Not defined: WRAP is treated as INCR, and the WRAP logic is not synthesised.

## Test plan
- Reset: hold rst 3 cycles, then release → arready 0 during reset and 1 one cycle after; m_axil_arvalid and s_axi_rvalid 0 throughout.
- INCR burst, araddr 0x10, len 3, size 1, id 0x5, user 1; m_axil_arready tied high → m_axil_araddr 0x10, 0x12, 0x14, 0x16 on consecutive cycles. Four R beats come back with rid 0x5 and ruser 1; rlast is high only on the 4th.
- FIXED burst, araddr 0x20, len 2 → three AXI-Lite reads, all at 0x20; rlast on the 3rd beat.
- Backpressure with OUTSTANDING_READS_WIDTH = 2, INCR len 7, m_axil_rvalid withheld → exactly 4 AR issued, then arvalid drops. Each R returned allows exactly one more AR; all 8 beats complete in order.
- Back-to-back bursts, id 0x1 len 1 then id 0x2 len 0, with s_axi_rready toggling every cycle → rid sequence 1, 1, 2 and rlast sequence 0, 1, 1; no beat is lost or duplicated.
- With SVC_AXI_AXIL_BURST_RD_WRAP_EN, WRAP araddr 0x0C, len 3, size 2 → addresses 0x0C, 0x00, 0x04, 0x08. Without the macro → 0x0C, 0x10, 0x14, 0x18.

Source files
------------

// File: rtl/svc_axi_axil_burst_rd.sv
// Purpose: AXI read bridge that splits FIXED/INCR (and WRAP when SVC_AXI_AXIL_BURST_RD_WRAP_EN is defined) bursts into single-beat AXI-Lite reads.
// Latency: first AXI-Lite AR one cycle after AR accept, then one beat per cycle; R path is a zero-latency pass-through.
// Backpressure: AR issue stalls while the beat tracker is full; R is forwarded only when s_axi_rready and the tracker hold a tag.

// Small synchronous FIFO that holds one tag per AXI-Lite read in flight.
// Latency: head valid the cycle after push; pop is combinational on the head.
// Backpressure: push ignored when full; pop ignored when empty.
module svc_axi_axil_burst_rd_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0]    r_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        o_empty   = (r_wr_ptr == r_rd_ptr);
        o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                    (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
        w_do_push = i_push && !o_full;
        w_do_pop  = i_pop && !o_empty;
        o_pop_dat = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    end

    // Pointer update; a reset flushes every stored tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_push_dat;
    end

endmodule

module svc_axi_axil_burst_rd #(
    parameter int AXI_ADDR_WIDTH          = 8,
    parameter int AXI_DATA_WIDTH          = 16,
    parameter int AXI_ID_WIDTH            = 4,
    parameter int AXI_USER_WIDTH          = 1,
    parameter int OUTSTANDING_READS_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic [AXI_USER_WIDTH-1:0] s_axi_aruser,

    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi_ruser,
    output logic                      s_axi_rlast,

    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,

    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                m_axil_rresp
);

    localparam int BYTES      = AXI_DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_USER_WIDTH-1:0] user;
        logic                      last;
    } trk_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;
    logic [2:0]                r_size;
    logic [1:0]                r_burst;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic [7:0]                r_beat;

    logic                      w_ar_accept;
    logic                      w_lite_ar_hs;
    logic                      w_last;
    logic [AXI_ADDR_WIDTH-1:0] w_beat_bytes;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_incr;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_nxt;
`ifdef SVC_AXI_AXIL_BURST_RD_WRAP_EN
    logic [AXI_ADDR_WIDTH-1:0] w_span;
    logic [AXI_ADDR_WIDTH-1:0] w_lower;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_wrap;
`endif

    trk_t                      w_trk_push;
    trk_t                      w_trk_head;
    logic                      w_trk_full;
    logic                      w_trk_empty;
    logic                      w_r_hs;

    // Handshake qualifiers shared by the FSM and the datapath.
    always_comb begin
        w_ar_accept  = s_axi_arvalid && s_axi_arready;
        w_lite_ar_hs = m_axil_arvalid && m_axil_arready;
        w_last       = (r_beat == r_len);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and AR-side handshake outputs; arready depends only on state and rst.
    always_comb begin
        w_state_nxt    = r_state;
        s_axi_arready  = 1'b0;
        m_axil_arvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                s_axi_arready = !rst;
                if (s_axi_arvalid && !rst) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                m_axil_arvalid = !w_trk_full && !rst;
                if (m_axil_arvalid && m_axil_arready && w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-beat address advance; size is already clamped to the bus width.
    always_comb begin
        w_beat_bytes = AXI_ADDR_WIDTH'(1) << r_size;
        w_addr_incr  = (r_addr & ~(w_beat_bytes - 1'b1)) + w_beat_bytes;
`ifdef SVC_AXI_AXIL_BURST_RD_WRAP_EN
        w_span       = w_beat_bytes * AXI_ADDR_WIDTH'({1'b0, r_len} + 9'd1);
        w_lower      = r_addr & ~(w_span - 1'b1);
        w_addr_wrap  = w_lower + ((r_addr + w_beat_bytes - w_lower) & (w_span - 1'b1));
`endif
        if (r_burst == 2'b00) begin
            w_addr_nxt = r_addr;
`ifdef SVC_AXI_AXIL_BURST_RD_WRAP_EN
        end else if (r_burst == 2'b10) begin
            w_addr_nxt = w_addr_wrap;
`endif
        end else begin
            w_addr_nxt = w_addr_incr;
        end
    end

    // Burst context capture on AR accept, then address/beat advance per issued beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_id    <= '0;
            r_user  <= '0;
            r_beat  <= '0;
        end else if (w_ar_accept) begin
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_size  <= (s_axi_arsize > 3'(LOG2_BYTES)) ? 3'(LOG2_BYTES) : s_axi_arsize;
            r_burst <= s_axi_arburst;
            r_id    <= s_axi_arid;
            r_user  <= s_axi_aruser;
            r_beat  <= '0;
        end else if (w_lite_ar_hs) begin
            r_addr  <= w_addr_nxt;
            r_beat  <= r_beat + 8'd1;
        end
    end

    // Tag pushed per issued AXI-Lite read so each response is labelled with its burst.
    always_comb begin
        w_trk_push.id   = r_id;
        w_trk_push.user = r_user;
        w_trk_push.last = w_last;
        m_axil_araddr   = r_addr;
    end

    svc_axi_axil_burst_rd_fifo #(
        .WIDTH      ($bits(trk_t)),
        .DEPTH_LOG2 (OUTSTANDING_READS_WIDTH)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_lite_ar_hs),
        .i_push_dat (w_trk_push),
        .i_pop      (w_r_hs),
        .o_pop_dat  (w_trk_head),
        .o_full     (w_trk_full),
        .o_empty    (w_trk_empty)
    );

    // R pass-through; a response with no outstanding tag is held off and never forwarded.
    always_comb begin
        s_axi_rvalid  = m_axil_rvalid && !w_trk_empty;
        m_axil_rready = s_axi_rready && !w_trk_empty;
        w_r_hs        = s_axi_rvalid && s_axi_rready;
        s_axi_rdata   = m_axil_rdata;
        s_axi_rresp   = m_axil_rresp;
        s_axi_rid     = w_trk_empty ? '0 : w_trk_head.id;
        s_axi_ruser   = w_trk_empty ? '0 : w_trk_head.user;
        s_axi_rlast   = w_trk_empty ? 1'b0 : w_trk_head.last;
    end

endmodule

// File: tb/tb_svc_axi_axil_burst_rd.sv
// Bench for svc_axi_axil_burst_rd: directed bursts with an AXI-Lite responder model and scoreboard queues.
// Runs at 32-bit data so a 4-byte beat size is legal; WRAP expectations follow SVC_AXI_AXIL_BURST_RD_WRAP_EN.
module tb_svc_axi_axil_burst_rd;

    logic        clk;
    logic        rst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [3:0]  s_axi_arid;
    logic [7:0]  s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic [0:0]  s_axi_aruser;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic [0:0]  s_axi_ruser;
    logic        s_axi_rlast;
    logic        m_axil_arvalid;
    logic        m_axil_arready;
    logic [7:0]  m_axil_araddr;
    logic        m_axil_rvalid;
    logic        m_axil_rready;
    logic [31:0] m_axil_rdata;
    logic [1:0]  m_axil_rresp;

    svc_axi_axil_burst_rd #(
        .AXI_ADDR_WIDTH          (8),
        .AXI_DATA_WIDTH          (32),
        .AXI_ID_WIDTH            (4),
        .AXI_USER_WIDTH          (1),
        .OUTSTANDING_READS_WIDTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_arid     (s_axi_arid),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_arsize   (s_axi_arsize),
        .s_axi_arburst  (s_axi_arburst),
        .s_axi_aruser   (s_axi_aruser),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .s_axi_rid      (s_axi_rid),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_ruser    (s_axi_ruser),
        .s_axi_rlast    (s_axi_rlast),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp)
    );

    typedef struct {
        logic [3:0] id;
        logic       user;
        logic       last;
        logic [7:0] addr;
    } exp_r_t;

    logic [7:0] exp_addr [$];
    exp_r_t     exp_r    [$];
    logic [7:0] lite_q   [$];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ar_cnt = 0;
    int   ar0;
    logic ar_acc;
    logic rsp_en;
    logic tog_rready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subordinate read data is a fixed function of the address so every beat is distinguishable.
    function automatic logic [31:0] lite_data(input logic [7:0] a);
        return {a, ~a, 8'h5A, a ^ 8'h3C};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [7:0] a, input logic [3:0] id, input logic user, input logic last);
        exp_r_t e;
        e.id = id; e.user = user; e.last = last; e.addr = a;
        exp_addr.push_back(a);
        exp_r.push_back(e);
    endtask

    // One clock: drive the responder, settle, score the handshakes that the coming edge completes.
    task automatic step();
        logic [7:0] la;
        logic [7:0] ea;
        exp_r_t     e;
        m_axil_rvalid = rsp_en && (lite_q.size() > 0);
        if (lite_q.size() > 0) begin
            la           = lite_q[0];
            m_axil_rdata = lite_data(la);
            m_axil_rresp = la[3:2];
        end
        if (tog_rready) s_axi_rready = ~s_axi_rready;
        #1;
        ar_acc = s_axi_arvalid && s_axi_arready;
        if (m_axil_arvalid && m_axil_arready) begin
            ar_cnt++;
            check("ar_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) begin
                ea = exp_addr.pop_front();
                check("ar_addr", 32'(m_axil_araddr), 32'(ea));
            end
            lite_q.push_back(m_axil_araddr);
        end
        if (s_axi_rvalid && s_axi_rready) begin
            check("r_expected", 32'(exp_r.size() != 0), 1);
            if (exp_r.size() != 0) begin
                e = exp_r.pop_front();
                check("rid",   32'(s_axi_rid),   32'(e.id));
                check("ruser", 32'(s_axi_ruser), 32'(e.user));
                check("rlast", 32'(s_axi_rlast), 32'(e.last));
                check("rdata", s_axi_rdata,      lite_data(e.addr));
                check("rresp", 32'(s_axi_rresp), 32'(e.addr[3:2]));
            end
        end
        if (m_axil_rvalid && m_axil_rready) void'(lite_q.pop_front());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic user, input logic [7:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_axi_arid    = id;
        s_axi_aruser  = user;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        ar_acc = 1'b0;
        n = 0;
        while (!ar_acc && n < 50) begin
            step();
            n++;
        end
        check("ar_accept", 32'(ar_acc), 1);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_addr.size() != 0 || exp_r.size() != 0) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(exp_addr.size() + exp_r.size()), 0);
    endtask

    initial begin
        rst            = 1'b1;
        s_axi_arvalid  = 1'b0;
        s_axi_arid     = '0;
        s_axi_araddr   = '0;
        s_axi_arlen    = '0;
        s_axi_arsize   = '0;
        s_axi_arburst  = '0;
        s_axi_aruser   = '0;
        s_axi_rready   = 1'b1;
        m_axil_arready = 1'b1;
        m_axil_rvalid  = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = '0;
        rsp_en         = 1'b0;
        tog_rready     = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_arready",  32'(s_axi_arready),  0);
            check("rst_arvalid",  32'(m_axil_arvalid), 0);
            check("rst_rvalid",   32'(s_axi_rvalid),   0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_arready", 32'(s_axi_arready),  1);
        check("post_rst_arvalid", 32'(m_axil_arvalid), 0);
        check("post_rst_araddr",  32'(m_axil_araddr),  0);
        check("post_rst_rvalid",  32'(s_axi_rvalid),   0);
        check("post_rst_rready",  32'(m_axil_rready),  0);
        check("post_rst_rlast",   32'(s_axi_rlast),    0);
        check("post_rst_rid",     32'(s_axi_rid),      0);
        check("post_rst_ruser",   32'(s_axi_ruser),    0);

        // INCR, 2-byte beats, issued back-to-back starting the cycle after accept.
        rsp_en = 1'b1;
        push_beat(8'h10, 4'h5, 1'b1, 1'b0);
        push_beat(8'h12, 4'h5, 1'b1, 1'b0);
        push_beat(8'h14, 4'h5, 1'b1, 1'b0);
        push_beat(8'h16, 4'h5, 1'b1, 1'b1);
        send_ar(4'h5, 1'b1, 8'h10, 8'd3, 3'd1, 2'd1);
        check("incr_arready_busy", 32'(s_axi_arready),  0);
        check("incr_first_arvalid", 32'(m_axil_arvalid), 1);
        check("incr_first_araddr", 32'(m_axil_araddr),  32'h10);
        ar0 = ar_cnt;
        repeat (4) step();
        check("incr_back_to_back", 32'(ar_cnt - ar0), 4);
        drain("incr");

        // FIXED burst repeats the start address.
        push_beat(8'h20, 4'h3, 1'b0, 1'b0);
        push_beat(8'h20, 4'h3, 1'b0, 1'b0);
        push_beat(8'h20, 4'h3, 1'b0, 1'b1);
        send_ar(4'h3, 1'b0, 8'h20, 8'd2, 3'd2, 2'd0);
        drain("fixed");

        // Tracker full: four reads outstanding, then one more per returned response.
        rsp_en = 1'b0;
        for (int i = 0; i < 8; i++) push_beat(8'(8'h40 + 4 * i), 4'hA, 1'b0, i == 7);
        ar0 = ar_cnt;
        send_ar(4'hA, 1'b0, 8'h40, 8'd7, 3'd2, 2'd1);
        repeat (8) step();
        check("bp_ar_count",    32'(ar_cnt - ar0),   4);
        check("bp_arvalid_low", 32'(m_axil_arvalid), 0);
        check("bp_rvalid_low",  32'(s_axi_rvalid),   0);
        rsp_en = 1'b1;
        step();
        rsp_en = 1'b0;
        repeat (3) step();
        check("bp_one_more_ar", 32'(ar_cnt - ar0), 5);
        rsp_en = 1'b1;
        drain("bp");

        // Back-to-back bursts with rready toggling every cycle.
        tog_rready = 1'b1;
        push_beat(8'h60, 4'h1, 1'b0, 1'b0);
        push_beat(8'h64, 4'h1, 1'b0, 1'b1);
        push_beat(8'h80, 4'h2, 1'b0, 1'b1);
        send_ar(4'h1, 1'b0, 8'h60, 8'd1, 3'd2, 2'd1);
        send_ar(4'h2, 1'b0, 8'h80, 8'd0, 3'd2, 2'd1);
        drain("b2b");
        tog_rready   = 1'b0;
        s_axi_rready = 1'b1;

        // WRAP burst: wraps inside a 16-byte span when enabled, otherwise behaves as INCR.
`ifdef SVC_AXI_AXIL_BURST_RD_WRAP_EN
        push_beat(8'h0C, 4'h7, 1'b1, 1'b0);
        push_beat(8'h00, 4'h7, 1'b1, 1'b0);
        push_beat(8'h04, 4'h7, 1'b1, 1'b0);
        push_beat(8'h08, 4'h7, 1'b1, 1'b1);
`else
        push_beat(8'h0C, 4'h7, 1'b1, 1'b0);
        push_beat(8'h10, 4'h7, 1'b1, 1'b0);
        push_beat(8'h14, 4'h7, 1'b1, 1'b0);
        push_beat(8'h18, 4'h7, 1'b1, 1'b1);
`endif
        send_ar(4'h7, 1'b1, 8'h0C, 8'd3, 3'd2, 2'd2);
        drain("wrap");

        // Reset mid-burst flushes the tracker; a stray AXI-Lite response is then held off.
        rsp_en = 1'b0;
        for (int i = 0; i < 8; i++) push_beat(8'(8'h40 + 4 * i), 4'hB, 1'b0, i == 7);
        send_ar(4'hB, 1'b0, 8'h40, 8'd7, 3'd2, 2'd1);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("midrst_arvalid", 32'(m_axil_arvalid), 0);
        check("midrst_arready", 32'(s_axi_arready),  0);
        exp_addr.delete();
        exp_r.delete();
        rst    = 1'b0;
        rsp_en = 1'b1;
        step();
        check("midrst_stray_rvalid", 32'(s_axi_rvalid),   0);
        check("midrst_stray_rready", 32'(m_axil_rready),  0);
        check("midrst_arready_back", 32'(s_axi_arready),  1);
        check("midrst_arvalid_idle", 32'(m_axil_arvalid), 0);
        rsp_en = 1'b0;
        lite_q.delete();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
